// File: rtl/pulse_train_gen_pkg.sv
// Shared definitions for the pulse train generator: FSM state encodings and
// default pulse/gap lengths for the common board strobes.
package pulse_train_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int PWR_BTN_PULSE_LEN = 100;
    localparam int PWR_BTN_GAP_LEN   = 10;
    localparam int RST_PULSE_LEN     = 20;
    localparam int RST_GAP_LEN       = 5;

    // States in which the phase timer is running.
    function automatic logic is_timed(input state_t s);
        return (s == ST_ASSERT) || (s == ST_GAP);
    endfunction

endpackage

// File: rtl/pulse_train_gen_phase_timer.sv
// Phase counter for the pulse train: counts 0..len-1 while enabled, clear wins,
// tc_o flags the last cycle of the current phase.
module phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == (len_i - 1'b1));

endmodule

// File: rtl/pulse_train_gen.sv
// Drives N glitch-free pulses of PULSE_LEN clocks, each followed by GAP_LEN idle clocks.
// Latency: start at edge T -> active output T+1; o_done at T+1+N*(PULSE_LEN+GAP_LEN).
// No backpressure: start while busy is dropped; PULSE_TRAIN_ABORT_EN adds i_abort.
module pulse_train_gen
    import pulse_train_gen_pkg::*;
#(
    parameter int   CNT_W      = 16,
    parameter int   PULSE_LEN  = PWR_BTN_PULSE_LEN,
    parameter int   GAP_LEN    = PWR_BTN_GAP_LEN,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [3:0] i_pulse_num,
`ifdef PULSE_TRAIN_ABORT_EN
    input  logic       i_abort,
`endif
    output logic       o_signal,
    output logic       o_busy,
    output logic       o_done
);

    localparam logic [CNT_W-1:0] PULSE_LEN_C = CNT_W'(PULSE_LEN);
    localparam logic [CNT_W-1:0] GAP_LEN_C   = CNT_W'(GAP_LEN);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] rem_q;
    logic [3:0] rem_d;
    logic       signal_q;
    logic       busy_q;
    logic       done_q;

    logic             abort_req;
    logic             in_phase;
    logic             phase_tc;
    logic             phase_end;
    logic             timer_clr;
    logic [CNT_W-1:0] phase_len;

`ifdef PULSE_TRAIN_ABORT_EN
    assign abort_req = i_abort && (state_q != ST_IDLE);
`else
    assign abort_req = 1'b0;
`endif

    assign in_phase  = is_timed(state_q);
    assign phase_len = (state_q == ST_ASSERT) ? PULSE_LEN_C : GAP_LEN_C;
    assign phase_end = in_phase && phase_tc;
    // The timer sits at zero outside timed phases so each phase starts from a clean count.
    assign timer_clr = !in_phase || phase_end || abort_req;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk_i   (i_clk),
        .rst_n_i (i_rst_n),
        .clr_i   (timer_clr),
        .en_i    (in_phase),
        .len_i   (phase_len),
        .tc_o    (phase_tc)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start && (i_pulse_num != 4'd0)) begin
                    state_d = ST_ASSERT;
                    rem_d   = i_pulse_num;
                end
            end
            ST_ASSERT: begin
                if (phase_tc) begin
                    state_d = ST_GAP;
                    rem_d   = rem_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (phase_tc) begin
                    state_d = (rem_q == 4'd0) ? ST_DONE : ST_ASSERT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort_req) begin
            state_d = ST_IDLE;
            rem_d   = 4'd0;
        end
    end

    // Outputs are decoded from the next state so the pin comes straight off a flop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            rem_q    <= 4'd0;
            signal_q <= IDLE_LEVEL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            signal_q <= (state_d == ST_ASSERT) ? ~IDLE_LEVEL : IDLE_LEVEL;
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= (state_d == ST_DONE);
        end
    end

    assign o_signal = signal_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen with PULSE_LEN=4, GAP_LEN=2, IDLE_LEVEL=1.
module tb_pulse_train_gen;

    localparam int PL = 4;
    localparam int GL = 2;

    typedef struct packed {
        logic sig;
        logic busy;
        logic done;
    } obs_t;

    typedef struct {
        logic [3:0] num;
        int         intr_cyc;
        logic [3:0] intr_num;
        int         exp_done;
        int         exp_edges;
    } vec_t;

    localparam obs_t IDLE_OBS = 3'b100;
    localparam obs_t PULSE_OBS = 3'b010;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [3:0] i_pulse_num = 4'd0;
`ifdef PULSE_TRAIN_ABORT_EN
    logic       i_abort = 1'b0;
`endif
    logic       o_signal;
    logic       o_busy;
    logic       o_done;

    int total = 0;
    int bad = 0;
    obs_t sb_q[$];
    vec_t vecs[6];

    pulse_train_gen #(
        .CNT_W      (16),
        .PULSE_LEN  (PL),
        .GAP_LEN    (GL),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_pulse_num (i_pulse_num),
`ifdef PULSE_TRAIN_ABORT_EN
        .i_abort     (i_abort),
`endif
        .o_signal    (o_signal),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int cyc, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got{sig,busy,done}=%b want=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Expected outputs k cycles after the edge that samples the start request.
    function automatic obs_t expect_at(input vec_t v, input int k);
        obs_t e;
        e = IDLE_OBS;
        if (v.exp_done != 0) begin
            if (k < v.exp_done) begin
                e.sig  = (((k - 1) % (PL + GL)) < PL) ? 1'b0 : 1'b1;
                e.busy = 1'b1;
            end else if (k == v.exp_done) begin
                e = 3'b111;
            end
        end
        return e;
    endfunction

    // Called at a negedge; drives the request and scores every following cycle.
    task automatic run_vec(input vec_t v, input int idx);
        int   len;
        int   falls;
        int   rises;
        logic prev;
        obs_t exp;
        len = (v.exp_done == 0) ? 6 : v.exp_done + 1;
        for (int k = 1; k <= len; k++) sb_q.push_back(expect_at(v, k));
        i_start     = 1'b1;
        i_pulse_num = v.num;
        prev  = o_signal;
        falls = 0;
        rises = 0;
        for (int k = 1; k <= len; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            i_start     = (k == v.intr_cyc);
            i_pulse_num = (k == v.intr_cyc) ? v.intr_num : 4'd0;
            if (sb_q.size() == 0) begin
                check_int($sformatf("vec%0d_sb_empty", idx), 0, 1);
            end else begin
                exp = sb_q.pop_front();
                check($sformatf("vec%0d", idx), k, {o_signal, o_busy, o_done}, exp);
            end
            if (prev && !o_signal) falls++;
            if (!prev && o_signal) rises++;
            prev = o_signal;
        end
        check_int($sformatf("vec%0d_falls", idx), falls, v.exp_edges);
        check_int($sformatf("vec%0d_rises", idx), rises, v.exp_edges);
    endtask

    initial begin
        vec_t rec;
        // {num, interfering start cycle, its num, done cycle, edge count}
        vecs[0] = '{4'd1, -1, 4'd0, 7, 1};
        vecs[1] = '{4'd3, -1, 4'd0, 19, 3};
        vecs[2] = '{4'd2, 2, 4'd3, 13, 2};
        vecs[3] = '{4'd0, -1, 4'd0, 0, 0};
        vecs[4] = '{4'd1, 7, 4'd2, 7, 1};
        vecs[5] = '{4'd15, -1, 4'd0, 91, 15};

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("in_reset", 0, {o_signal, o_busy, o_done}, IDLE_OBS);
        i_rst_n = 1'b1;

        for (int k = 1; k <= 20; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            check("post_reset_idle", k, {o_signal, o_busy, o_done}, IDLE_OBS);
        end

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset in the middle of a pulse.
        i_start     = 1'b1;
        i_pulse_num = 4'd1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start     = 1'b0;
        i_pulse_num = 4'd0;
        check("rst_pre", 1, {o_signal, o_busy, o_done}, PULSE_OBS);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("rst_async", 2, {o_signal, o_busy, o_done}, IDLE_OBS);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            check("rst_after", k, {o_signal, o_busy, o_done}, IDLE_OBS);
        end
        rec = '{4'd2, -1, 4'd0, 13, 2};
        run_vec(rec, 10);

`ifdef PULSE_TRAIN_ABORT_EN
        i_start     = 1'b1;
        i_pulse_num = 4'd2;
        for (int k = 1; k <= 3; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            i_start     = 1'b0;
            i_pulse_num = 4'd0;
            check("abort_pre", k, {o_signal, o_busy, o_done}, PULSE_OBS);
            if (k == 3) i_abort = 1'b1;
        end
        @(posedge i_clk);
        @(negedge i_clk);
        i_abort = 1'b0;
        check("abort_cut", 4, {o_signal, o_busy, o_done}, IDLE_OBS);
        rec = '{4'd1, -1, 4'd0, 7, 1};
        run_vec(rec, 11);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
